mux_4_to_1_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 4:1 mux datapath among four requesters. It owns the select lines S1/S0 and grants exactly one requester at a time. It steers the granted input I0..I3 onto Y and flags when Y carries valid owned data. It sits in front of the 4:1 mux, replacing static select stimulus with arbitrated, clocked control.

---
 rtl/mux_4_to_1_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mux_4_to_1_rr_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/mux_4_to_1_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 mux.
// Define MUX_ARB_TIMEOUT_EN to force the owner out after MAX_HOLD cycles when others wait.
module mux_4_to_1_rr_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  output logic [3:0]       gnt,
  output logic             S1,
  output logic             S0,
  output logic [WIDTH-1:0] Y,
  output logic             Y_valid
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic       found;
  logic [1:0] pick;
  logic       keep;
  logic       force_rot;

  // Search starts one past the last owner, so the last owner always ranks last.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!found && req[last_q + 2'(k)]) begin
        found = 1'b1;
        pick  = last_q + 2'(k);
      end
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q;

  assign force_rot = (hold_q == HOLD_MAX) && |(req & ~gnt);

  always_ff @(posedge clk) begin
    if (rst)
      hold_q <= '0;
    else if (keep)
      hold_q <= (hold_q == HOLD_MAX) ? hold_q : hold_q + 8'd1;
    else
      hold_q <= '0;
  end
`else
  assign force_rot = 1'b0;
`endif

  // In BUSY, last_q always names the current owner.
  assign keep = (state_q == BUSY) && req[last_q] && !force_rot;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel_q;
    last_d  = last_q;
    if (!keep) begin
      if (found) begin
        state_d = BUSY;
        gnt_d   = 4'b0001 << pick;
        sel_d   = pick;
        last_d  = pick;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign S1      = sel_q[1];
  assign S0      = sel_q[0];
  assign Y_valid = |gnt;

  always_comb begin
    Y = '0;
    if (Y_valid) begin
      case (sel_q)
        2'd0:    Y = I0;
        2'd1:    Y = I1;
        2'd2:    Y = I2;
        default: Y = I3;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4_to_1_rr_arbiter.sv
// Directed-vector bench for mux_4_to_1_rr_arbiter, plus hold/timeout sequences.
module tb_mux_4_to_1_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] I0, I1, I2, I3;
  logic [3:0] gnt;
  logic       S1, S0;
  logic [3:0] Y;
  logic       Y_valid;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  mux_4_to_1_rr_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .I0(I0), .I1(I1), .I2(I2), .I3(I3),
    .gnt(gnt), .S1(S1), .S0(S0), .Y(Y), .Y_valid(Y_valid)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] i0, i1, i2, i3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       v;
    logic [3:0] y;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq);
    @(negedge clk);
    rst = r;
    req = rq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; I0 = 4'hA; I1 = 4'h5; I2 = 4'hC; I3 = 4'h3;

    //           rst   req      i0    i1    i2    i3    gnt      sel    v     y
    vecs[0]  = '{1'b1, 4'b1111, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0000, 2'd0, 1'b0, 4'h0};
    vecs[1]  = '{1'b0, 4'b0001, 4'h1, 4'h0, 4'hC, 4'h3, 4'b0001, 2'd0, 1'b1, 4'h1};
    vecs[2]  = '{1'b0, 4'b0000, 4'h1, 4'h0, 4'hC, 4'h3, 4'b0000, 2'd0, 1'b0, 4'h0};
    vecs[3]  = '{1'b1, 4'b0000, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0000, 2'd0, 1'b0, 4'h0};
    vecs[4]  = '{1'b0, 4'b1111, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0001, 2'd0, 1'b1, 4'hA};
    vecs[5]  = '{1'b0, 4'b1110, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0010, 2'd1, 1'b1, 4'h5};
    vecs[6]  = '{1'b0, 4'b1100, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0100, 2'd2, 1'b1, 4'hC};
    vecs[7]  = '{1'b0, 4'b1000, 4'hA, 4'h5, 4'hC, 4'h3, 4'b1000, 2'd3, 1'b1, 4'h3};
    vecs[8]  = '{1'b0, 4'b0000, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0000, 2'd3, 1'b0, 4'h0};
    vecs[9]  = '{1'b0, 4'b0101, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0001, 2'd0, 1'b1, 4'hA};
    vecs[10] = '{1'b0, 4'b0100, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0100, 2'd2, 1'b1, 4'hC};
    vecs[11] = '{1'b0, 4'b0101, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0100, 2'd2, 1'b1, 4'hC};
    vecs[12] = '{1'b0, 4'b0001, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0001, 2'd0, 1'b1, 4'hA};
    vecs[13] = '{1'b0, 4'b0000, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0000, 2'd0, 1'b0, 4'h0};
    vecs[14] = '{1'b0, 4'b0100, 4'hA, 4'h5, 4'h9, 4'h3, 4'b0100, 2'd2, 1'b1, 4'h9};
    vecs[15] = '{1'b1, 4'b1111, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0000, 2'd0, 1'b0, 4'h0};
    vecs[16] = '{1'b0, 4'b1111, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0001, 2'd0, 1'b1, 4'hA};
    vecs[17] = '{1'b0, 4'b1010, 4'hA, 4'h5, 4'hC, 4'h3, 4'b0010, 2'd1, 1'b1, 4'h5};
    vecs[18] = '{1'b0, 4'b1001, 4'hA, 4'h5, 4'hC, 4'h3, 4'b1000, 2'd3, 1'b1, 4'h3};
    vecs[19] = '{1'b0, 4'b0001, 4'hA, 4'h7, 4'hC, 4'h3, 4'b0001, 2'd0, 1'b1, 4'hA};

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      I0 = vecs[i].i0; I1 = vecs[i].i1; I2 = vecs[i].i2; I3 = vecs[i].i3;
      rst = vecs[i].rst;
      req = vecs[i].req;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d gnt", i), gnt, vecs[i].gnt);
      check($sformatf("vec%0d sel", i), {2'b00, S1, S0}, {2'b00, vecs[i].sel});
      check($sformatf("vec%0d valid", i), {3'b000, Y_valid}, {3'b000, vecs[i].v});
      check($sformatf("vec%0d y", i), Y, vecs[i].y);
    end

    I0 = 4'hA; I1 = 4'h5; I2 = 4'hC; I3 = 4'h3;
    step(1'b1, 4'b0000);
    check("seq reset gnt", gnt, 4'b0000);

`ifdef MUX_ARB_TIMEOUT_EN
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 4'b0011);
      check($sformatf("timeout c%0d gnt", c), gnt, ((c / 4) % 2 == 0) ? 4'b0001 : 4'b0010);
    end
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 4'b0001);
      check($sformatf("sole c%0d gnt", c), gnt, 4'b0001);
    end
`else
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 4'b0011);
      check($sformatf("hold c%0d gnt", c), gnt, 4'b0001);
    end
    step(1'b0, 4'b0010);
    check("hold release gnt", gnt, 4'b0010);
    check("hold release y", Y, 4'h5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
